// File: rtl/audio_pio_pkg.sv
// Shared register map and edge-select encodings for the audio PIO blocks.
package audio_pio_pkg;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_DIR  = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_SET  = 3'd4;
    localparam logic [2:0] ADDR_CLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/audio_pio_sync.sv
// Multi-flop synchroniser vector, reset to 0; SYNC_STAGES clocks latency.
module audio_pio_sync #(
    parameter int WIDTH       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_stage[s] <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int s = 1; s < SYNC_STAGES; s++) r_stage[s] <= r_stage[s-1];
        end
    end

    assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/audio_bidir_pio.sv
// Avalon-MM bidirectional PIO for codec control pins: per-bit direction, open-drain option,
// edge capture (W1C, edge wins over clear) and maskable level irq; readdata registered, 1 clock.
module audio_bidir_pio
    import audio_pio_pkg::*;
#(
    parameter int               WIDTH       = 2,
    parameter int               OPEN_DRAIN  = 0,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_MODE   = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    inout  wire  [WIDTH-1:0] bidir_port
);

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_prev;

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_sync_q;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_rd_mux;
    logic             w_unused_wd;

    assign w_wr        = chipselect && !write_n;
    assign w_wd        = writedata[WIDTH-1:0];
    assign w_unused_wd = ^writedata;

    // Open-drain pins only ever pull low; the external pull-up supplies the high level.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        if (OPEN_DRAIN != 0) begin : g_od
            assign bidir_port[i] = (r_dir[i] && !r_out[i]) ? 1'b0 : 1'bz;
        end else begin : g_pp
            assign bidir_port[i] = r_dir[i] ? r_out[i] : 1'bz;
        end
    end

    audio_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (bidir_port),
        .o_q     (w_sync_q)
    );

    assign w_rise = w_sync_q & ~r_prev;
    assign w_fall = ~w_sync_q & r_prev;
    assign w_edge = (EDGE_MODE == EDGE_RISE) ? w_rise :
                    (EDGE_MODE == EDGE_FALL) ? w_fall : (w_rise | w_fall);
    assign w_clr  = (w_wr && address == ADDR_EDGE) ? w_wd : '0;

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA: w_rd_mux = w_sync_q;
            ADDR_DIR:  w_rd_mux = r_dir;
            ADDR_MASK: w_rd_mux = r_mask;
            ADDR_EDGE: w_rd_mux = r_edge;
            default:   w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out    <= RESET_OUT;
            r_dir    <= RESET_DIR;
            r_mask   <= '0;
            r_edge   <= '0;
            r_prev   <= '0;
            readdata <= '0;
        end else begin
            r_prev   <= w_sync_q;
            readdata <= 32'(w_rd_mux);
            // A new edge overrides a same-cycle clear so no event is lost.
            r_edge   <= (r_edge & ~w_clr) | w_edge;
            if (w_wr) begin
                case (address)
                    ADDR_DATA: r_out  <= w_wd;
                    ADDR_SET:  r_out  <= r_out | w_wd;
                    ADDR_CLR:  r_out  <= r_out & ~w_wd;
                    ADDR_DIR:  r_dir  <= w_wd;
                    ADDR_MASK: r_mask <= w_wd;
                    default: ;
                endcase
            end
        end
    end

    assign irq = |(r_edge & r_mask);

endmodule

// File: tb/tb_audio_bidir_pio.sv
// Directed bench: push-pull/falling-edge instance with pull-down, open-drain/any-edge instance with pull-up.
module tb_audio_bidir_pio;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        cs_pp = 1'b0;
    logic        cs_od = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] rd_pp;
    logic [31:0] rd_od;
    logic        irq_pp;
    logic        irq_od;
    wire  [1:0]  pins_pp;
    wire  [1:0]  pins_od;
    logic        ext_en_pp = 1'b0;
    logic        ext_val_pp = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pulldown (pins_pp[0]);
    pulldown (pins_pp[1]);
    pullup   (pins_od[0]);
    pullup   (pins_od[1]);
    assign pins_pp[1] = ext_en_pp ? ext_val_pp : 1'bz;

    audio_bidir_pio #(
        .WIDTH(2), .OPEN_DRAIN(0), .SYNC_STAGES(2), .EDGE_MODE(1),
        .RESET_OUT(2'b00), .RESET_DIR(2'b00)
    ) u_pp (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_pp),
        .write_n(write_n), .writedata(writedata), .readdata(rd_pp),
        .irq(irq_pp), .bidir_port(pins_pp)
    );

    audio_bidir_pio #(
        .WIDTH(2), .OPEN_DRAIN(1), .SYNC_STAGES(2), .EDGE_MODE(2),
        .RESET_OUT(2'b00), .RESET_DIR(2'b00)
    ) u_od (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_od),
        .write_n(write_n), .writedata(writedata), .readdata(rd_od),
        .irq(irq_od), .bidir_port(pins_od)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Write is taken on the posedge between the two negedges; returns with registers updated.
    task automatic wr(input logic od, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; write_n = 1'b0;
        cs_pp = !od; cs_od = od;
        @(negedge clk);
        write_n = 1'b1; cs_pp = 1'b0; cs_od = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        @(negedge clk);
        address = a;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rd_pp", rd_pp, 32'h0);
        chk("rst_irq_pp", {31'd0, irq_pp}, 32'h0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_pins_pp", {30'd0, pins_pp}, 32'h0);
        chk("rst_pins_od", {30'd0, pins_od}, 32'h3);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            chk($sformatf("rst_rd_a%0d", a), rd_pp, 32'h0);
        end
        chk("rst_irq_od", {31'd0, irq_od}, 32'h0);

        // Open-drain: pull-up seen after reset is an any-edge rise on both bits
        rd(3'd3);
        chk("od_edge_rst", rd_od, 32'h3);
        wr(1'b1, 3'd3, 32'h3);
        rd(3'd3);
        chk("od_edge_clr", rd_od, 32'h0);
        wr(1'b1, 3'd1, 32'h3);
        wr(1'b1, 3'd0, 32'h1);
        chk("od_pins_01", {30'd0, pins_od}, 32'h1);
        repeat (3) @(negedge clk);
        rd(3'd0);
        chk("od_rd_data", rd_od, 32'h1);
        wr(1'b1, 3'd0, 32'h0);
        chk("od_pins_00", {30'd0, pins_od}, 32'h0);

        // Push-pull output and synchroniser latency
        wr(1'b0, 3'd1, 32'h3);
        wr(1'b0, 3'd0, 32'h2);
        chk("pp_pins_10", {30'd0, pins_pp}, 32'h2);
        @(negedge clk);
        @(negedge clk);
        chk("pp_rd_early", rd_pp, 32'h0);
        @(negedge clk);
        chk("pp_rd_lat", rd_pp, 32'h2);
        rd(3'd1);
        chk("pp_rd_dir", rd_pp, 32'h3);

        // Set/clear aliases
        wr(1'b0, 3'd0, 32'h3);
        wr(1'b0, 3'd4, 32'h0);
        wr(1'b0, 3'd5, 32'h1);
        chk("pp_alias_10", {30'd0, pins_pp}, 32'h2);
        wr(1'b0, 3'd4, 32'h1);
        chk("pp_set_11", {30'd0, pins_pp}, 32'h3);
        wr(1'b0, 3'd5, 32'h1);
        chk("pp_clr_10", {30'd0, pins_pp}, 32'h2);
        rd(3'd4);
        chk("pp_rd_set", rd_pp, 32'h0);
        rd(3'd5);
        chk("pp_rd_clr", rd_pp, 32'h0);
        rd(3'd6);
        chk("pp_rd_a6", rd_pp, 32'h0);
        wr(1'b0, 3'd0, 32'hFFFF_FFFD);
        repeat (3) @(negedge clk);
        rd(3'd0);
        chk("pp_rd_upper", rd_pp, 32'h1);

        // Falling edges from the above sequence on both bits
        wr(1'b0, 3'd1, 32'h0);
        repeat (4) @(negedge clk);
        rd(3'd3);
        chk("pp_edge_pre", rd_pp, 32'h3);
        wr(1'b0, 3'd3, 32'h3);
        rd(3'd3);
        chk("pp_edge_clr", rd_pp, 32'h0);
        wr(1'b0, 3'd2, 32'h2);

        // Rising edge ignored in falling mode
        @(negedge clk);
        ext_en_pp = 1'b1; ext_val_pp = 1'b1;
        repeat (4) @(negedge clk);
        rd(3'd3);
        chk("pp_rise_ign", rd_pp, 32'h0);
        chk("pp_irq_rise", {31'd0, irq_pp}, 32'h0);

        // Falling edge latency to irq
        @(negedge clk);
        ext_val_pp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pp_irq_early", {31'd0, irq_pp}, 32'h0);
        @(negedge clk);
        chk("pp_irq_set", {31'd0, irq_pp}, 32'h1);
        rd(3'd3);
        chk("pp_edge_fall", rd_pp, 32'h2);

        // Write-0 bits keep capture; mask gating
        wr(1'b0, 3'd3, 32'h1);
        chk("pp_w0_irq", {31'd0, irq_pp}, 32'h1);
        rd(3'd3);
        chk("pp_w0_edge", rd_pp, 32'h2);
        wr(1'b0, 3'd2, 32'h0);
        chk("pp_mask_off", {31'd0, irq_pp}, 32'h0);
        wr(1'b0, 3'd2, 32'h2);
        chk("pp_mask_on", {31'd0, irq_pp}, 32'h1);
        wr(1'b0, 3'd3, 32'h2);
        chk("pp_w1c_irq", {31'd0, irq_pp}, 32'h0);
        rd(3'd3);
        chk("pp_w1c_edge", rd_pp, 32'h0);

        // Edge coinciding with clear: edge wins
        @(negedge clk);
        ext_val_pp = 1'b1;
        repeat (4) @(negedge clk);
        ext_val_pp = 1'b0;
        @(negedge clk);
        wr(1'b0, 3'd3, 32'h2);
        chk("pp_coinc_irq", {31'd0, irq_pp}, 32'h1);
        rd(3'd3);
        chk("pp_coinc_edge", rd_pp, 32'h2);

        // Asynchronous reset mid-operation
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        ext_en_pp = 1'b0;
        #1;
        chk("arst_irq", {31'd0, irq_pp}, 32'h0);
        chk("arst_rd", rd_pp, 32'h0);
        chk("arst_pins_od", {30'd0, pins_od}, 32'h3);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        rd(3'd1);
        chk("arst_dir", rd_pp, 32'h0);
        rd(3'd2);
        chk("arst_mask", rd_pp, 32'h0);
        rd(3'd3);
        chk("arst_edge", rd_pp, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
